// File: rtl/rv32_pkg.sv
// Shared RV32I decode definitions.
// Opcodes, opclass and immediate-format enums, ID/EX bundle.
package rv32_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    OC_LUI,
    OC_AUIPC,
    OC_JAL,
    OC_JALR,
    OC_BRANCH,
    OC_LOAD,
    OC_STORE,
    OC_OPIMM,
    OC_OP,
    OC_FENCE,
    OC_SYSTEM
  } opclass_e;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rd;
    opclass_e        opclass;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic            illegal;
  } id_ex_t;

endpackage

// File: rtl/rv32_imm_gen.sv
// RV32I immediate generator.
// Sign-extends from instr[31]; B/J are halfword aligned.
module rv32_imm_gen
  import rv32_pkg::*;
(
  input  logic [31:0]     instr_i,
  input  imm_fmt_e        fmt_i,
  output logic [XLEN-1:0] imm_o
);

  logic s;

  assign s = instr_i[31];

  // Assemble the immediate for the selected format
  always_comb begin
    imm_o = '0;
    unique case (fmt_i)
      IMM_I: imm_o = {{20{s}}, instr_i[31:20]};
      IMM_S: imm_o = {{20{s}}, instr_i[31:25],
                      instr_i[11:7]};
      IMM_B: imm_o = {{19{s}}, s, instr_i[7],
                      instr_i[30:25], instr_i[11:8],
                      1'b0};
      IMM_U: imm_o = {instr_i[31:12], 12'b0};
      IMM_J: imm_o = {{11{s}}, s, instr_i[19:12],
                      instr_i[20], instr_i[30:21],
                      1'b0};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/rv32_decode_stage.sv
// RV32I decode stage with scoreboard and wb bypass.
// One-entry ID/EX register toward execute.
module rv32_decode_stage
  import rv32_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     in_instr_i,
  input  logic [XLEN-1:0] in_pc_i,
  output logic [4:0]      rf_raddr1_o,
  output logic [4:0]      rf_raddr2_o,
  input  logic [XLEN-1:0] rf_rdata1_i,
  input  logic [XLEN-1:0] rf_rdata2_i,
  input  logic            wb_valid_i,
  input  logic            wb_wen_i,
  input  logic [4:0]      wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  input  logic            flush_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_pc_o,
  output logic [XLEN-1:0] out_imm_o,
  output logic [XLEN-1:0] out_rs1_data_o,
  output logic [XLEN-1:0] out_rs2_data_o,
  output logic [4:0]      out_rd_o,
  output logic [3:0]      out_opclass_o,
  output logic [2:0]      out_funct3_o,
  output logic            out_funct7b5_o,
  output logic            out_illegal_o
);

  logic [6:0]      opc;
  logic [4:0]      rs1, rs2, rd;
  opclass_e        oc;
  imm_fmt_e        fmt;
  logic            use1, use2, wr_rd, ill;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] op1, op2;
  logic            byp1, byp2;

  id_ex_t          out_q, out_d;
  logic            out_valid_q, out_valid_d;
  logic [31:0]     pend_q, pend_d;
  logic [31:0]     clr_m, set_m, kill_m, eff;
  logic            hazard, accept;

  assign opc = in_instr_i[6:0];
  assign rs1 = in_instr_i[19:15];
  assign rs2 = in_instr_i[24:20];

  assign rf_raddr1_o = rs1;
  assign rf_raddr2_o = rs2;

  // Opcode decode: class, imm format, operand use
  always_comb begin
    oc    = OC_OP;
    fmt   = IMM_NONE;
    use1  = 1'b0;
    use2  = 1'b0;
    wr_rd = 1'b0;
    ill   = 1'b0;
    unique case (1'b1)
      (opc == OPC_LUI): begin
        oc = OC_LUI; fmt = IMM_U; wr_rd = 1'b1;
      end
      (opc == OPC_AUIPC): begin
        oc = OC_AUIPC; fmt = IMM_U; wr_rd = 1'b1;
      end
      (opc == OPC_JAL): begin
        oc = OC_JAL; fmt = IMM_J; wr_rd = 1'b1;
      end
      (opc == OPC_JALR): begin
        oc = OC_JALR; fmt = IMM_I;
        use1 = 1'b1; wr_rd = 1'b1;
      end
      (opc == OPC_BRANCH): begin
        oc = OC_BRANCH; fmt = IMM_B;
        use1 = 1'b1; use2 = 1'b1;
      end
      (opc == OPC_LOAD): begin
        oc = OC_LOAD; fmt = IMM_I;
        use1 = 1'b1; wr_rd = 1'b1;
      end
      (opc == OPC_STORE): begin
        oc = OC_STORE; fmt = IMM_S;
        use1 = 1'b1; use2 = 1'b1;
      end
      (opc == OPC_OPIMM): begin
        oc = OC_OPIMM; fmt = IMM_I;
        use1 = 1'b1; wr_rd = 1'b1;
      end
      (opc == OPC_OP): begin
        oc = OC_OP;
        use1 = 1'b1; use2 = 1'b1; wr_rd = 1'b1;
      end
      (opc == OPC_FENCE): begin
        oc = OC_FENCE;
      end
      (opc == OPC_SYSTEM): begin
        oc = OC_SYSTEM; fmt = IMM_I;
        use1 = 1'b1; wr_rd = 1'b1;
      end
      default: ill = 1'b1;
    endcase
  end

  assign rd = wr_rd ? in_instr_i[11:7] : 5'd0;

  rv32_imm_gen u_imm (
    .instr_i (in_instr_i),
    .fmt_i   (fmt),
    .imm_o   (imm)
  );

  // A retiring rd no longer blocks this cycle
  assign clr_m = (wb_valid_i && wb_rd_i != 5'd0)
               ? (32'd1 << wb_rd_i) : 32'd0;
  assign eff   = pend_q & ~clr_m;

  assign hazard = in_valid_i &&
                  ((use1 && eff[rs1]) ||
                   (use2 && eff[rs2]) ||
                   eff[rd]);

  assign in_ready_o = !flush_i && !hazard &&
                      (!out_valid_q || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;

  assign byp1 = use1 && rs1 != 5'd0 && wb_valid_i &&
                wb_wen_i && wb_rd_i == rs1;
  assign byp2 = use2 && rs2 != 5'd0 && wb_valid_i &&
                wb_wen_i && wb_rd_i == rs2;
  assign op1  = byp1 ? wb_data_i : rf_rdata1_i;
  assign op2  = byp2 ? wb_data_i : rf_rdata2_i;

  // Flushed output entry never reaches wb; drop its bit
  assign kill_m = (flush_i && out_valid_q &&
                   out_q.rd != 5'd0)
                ? (32'd1 << out_q.rd) : 32'd0;
  assign set_m  = (accept && rd != 5'd0)
                ? (32'd1 << rd) : 32'd0;

  // Scoreboard next state; a new set beats any clear
  always_comb begin
    pend_d = (pend_q & ~clr_m & ~kill_m) | set_m;
    pend_d[0] = 1'b0;
  end

  // Next ID/EX payload and valid
  always_comb begin
    out_d.pc       = in_pc_i;
    out_d.imm      = imm;
    out_d.rs1_data = op1;
    out_d.rs2_data = op2;
    out_d.rd       = rd;
    out_d.opclass  = oc;
    out_d.funct3   = in_instr_i[14:12];
    out_d.funct7b5 = in_instr_i[30];
    out_d.illegal  = ill;
    out_valid_d    = out_valid_q;
    if (flush_i)
      out_valid_d = 1'b0;
    else if (accept)
      out_valid_d = 1'b1;
    else if (out_valid_q && out_ready_i)
      out_valid_d = 1'b0;
  end

  // State registers: output entry and scoreboard
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      pend_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      pend_q      <= pend_d;
      if (accept)
        out_q <= out_d;
    end
  end

  assign out_valid_o    = out_valid_q;
  assign out_pc_o       = out_q.pc;
  assign out_imm_o      = out_q.imm;
  assign out_rs1_data_o = out_q.rs1_data;
  assign out_rs2_data_o = out_q.rs2_data;
  assign out_rd_o       = out_q.rd;
  assign out_opclass_o  = out_q.opclass;
  assign out_funct3_o   = out_q.funct3;
  assign out_funct7b5_o = out_q.funct7b5;
  assign out_illegal_o  = out_q.illegal;

endmodule

// File: tb/tb_rv32_decode_stage.sv
// Bench for rv32_decode_stage: decode table,
// directed corner sequences, random run vs model.
module tb_rv32_decode_stage;
  import rv32_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_instr, in_pc;
  logic [4:0]  ra1, ra2;
  logic [31:0] rd1, rd2;
  logic        wb_valid, wb_wen;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush, out_valid, out_ready;
  logic [31:0] o_pc, o_imm, o_rs1, o_rs2;
  logic [4:0]  o_rd;
  logic [3:0]  o_oc;
  logic [2:0]  o_f3;
  logic        o_f7, o_ill;

  logic [31:0] rf [32];

  always #5 clk = ~clk;

  assign rd1 = (ra1 == 5'd0) ? 32'd0 : rf[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : rf[ra2];

  rv32_decode_stage dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .in_instr_i     (in_instr),
    .in_pc_i        (in_pc),
    .rf_raddr1_o    (ra1),
    .rf_raddr2_o    (ra2),
    .rf_rdata1_i    (rd1),
    .rf_rdata2_i    (rd2),
    .wb_valid_i     (wb_valid),
    .wb_wen_i       (wb_wen),
    .wb_rd_i        (wb_rd),
    .wb_data_i      (wb_data),
    .flush_i        (flush),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_pc_o       (o_pc),
    .out_imm_o      (o_imm),
    .out_rs1_data_o (o_rs1),
    .out_rs2_data_o (o_rs2),
    .out_rd_o       (o_rd),
    .out_opclass_o  (o_oc),
    .out_funct3_o   (o_f3),
    .out_funct7b5_o (o_f7),
    .out_illegal_o  (o_ill)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h",
                  nm, act, exp);
  endtask

  // Reference model state
  bit          m_valid;
  logic [31:0] m_pc, m_imm, m_rs1, m_rs2;
  logic [4:0]  m_rd;
  logic [3:0]  m_oc;
  logic [2:0]  m_f3;
  logic        m_f7, m_ill;
  int          outstanding[$];
  int          ex_q[$];
  bit          auto_wb;
  bit          last_rdy;

  typedef struct packed {
    logic        u1;
    logic        u2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [3:0]  oc;
    logic        ill;
  } dec_t;

  function automatic dec_t ref_dec(logic [31:0] w);
    dec_t d;
    logic [31:0] s;
    logic [31:0] ii;
    s  = w[31] ? 32'hFFFF_FFFF : 32'h0;
    ii = (s << 12) | 32'(w[31:20]);
    d  = '0;
    case (w[6:0])
      7'h37: begin
        d.oc = OC_LUI; d.rd = w[11:7];
        d.imm = w & 32'hFFFF_F000;
      end
      7'h17: begin
        d.oc = OC_AUIPC; d.rd = w[11:7];
        d.imm = w & 32'hFFFF_F000;
      end
      7'h6F: begin
        d.oc = OC_JAL; d.rd = w[11:7];
        d.imm = (s << 20) | (32'(w[19:12]) << 12)
              | (32'(w[20]) << 11)
              | (32'(w[30:21]) << 1);
      end
      7'h67: begin
        d.oc = OC_JALR; d.rd = w[11:7];
        d.u1 = 1'b1; d.imm = ii;
      end
      7'h63: begin
        d.oc = OC_BRANCH; d.u1 = 1'b1; d.u2 = 1'b1;
        d.imm = (s << 12) | (32'(w[7]) << 11)
              | (32'(w[30:25]) << 5)
              | (32'(w[11:8]) << 1);
      end
      7'h03: begin
        d.oc = OC_LOAD; d.rd = w[11:7];
        d.u1 = 1'b1; d.imm = ii;
      end
      7'h23: begin
        d.oc = OC_STORE; d.u1 = 1'b1; d.u2 = 1'b1;
        d.imm = (s << 12) | (32'(w[31:25]) << 5)
              | 32'(w[11:7]);
      end
      7'h13: begin
        d.oc = OC_OPIMM; d.rd = w[11:7];
        d.u1 = 1'b1; d.imm = ii;
      end
      7'h33: begin
        d.oc = OC_OP; d.rd = w[11:7];
        d.u1 = 1'b1; d.u2 = 1'b1;
      end
      7'h0F: d.oc = OC_FENCE;
      7'h73: begin
        d.oc = OC_SYSTEM; d.rd = w[11:7];
        d.u1 = 1'b1; d.imm = ii;
      end
      default: d.ill = 1'b1;
    endcase
    return d;
  endfunction

  function automatic bit busy(int r, int ret);
    if (r == 0 || r == ret) return 1'b0;
    foreach (outstanding[i])
      if (outstanding[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic remove(int r);
    for (int i = 0; i < outstanding.size(); i++)
      if (outstanding[i] == r) begin
        outstanding.delete(i);
        return;
      end
  endtask

  // One clock: called at negedge with inputs set
  task automatic cycle();
    dec_t        d;
    int          ret;
    bit          haz, erdy, acc;
    logic [4:0]  r1, r2;
    logic [31:0] v1, v2;
    if (auto_wb) begin
      wb_valid = 1'b0;
      wb_wen   = 1'b0;
      wb_rd    = 5'd0;
      wb_data  = $urandom;
      if (ex_q.size() > 0 && $urandom_range(1, 0) == 1) begin
        wb_valid = 1'b1;
        wb_rd    = 5'(ex_q.pop_front());
        wb_wen   = ($urandom_range(7, 0) != 0);
      end else if ($urandom_range(9, 0) == 0) begin
        wb_valid = 1'b1;
        wb_wen   = 1'b1;
      end
    end
    #2;
    d   = ref_dec(in_instr);
    r1  = in_instr[19:15];
    r2  = in_instr[24:20];
    ret = (wb_valid && wb_rd != 0) ? int'(wb_rd) : -1;
    haz = in_valid &&
          ((d.u1 && busy(r1, ret)) ||
           (d.u2 && busy(r2, ret)) ||
           busy(d.rd, ret));
    erdy = !flush && !haz && (!m_valid || out_ready);
    last_rdy = in_ready;
    chk("in_ready", in_ready, erdy);
    chk("raddr1", ra1, r1);
    chk("raddr2", ra2, r2);
    acc = in_valid && erdy;
    v1 = (r1 == 0) ? 32'd0 : rf[r1];
    v2 = (r2 == 0) ? 32'd0 : rf[r2];
    if (d.u1 && r1 != 0 && wb_valid && wb_wen && wb_rd == r1)
      v1 = wb_data;
    if (d.u2 && r2 != 0 && wb_valid && wb_wen && wb_rd == r2)
      v2 = wb_data;
    @(posedge clk);
    #1;
    if (wb_valid && wb_rd != 0) remove(wb_rd);
    if (wb_valid && wb_wen && wb_rd != 0) rf[wb_rd] = wb_data;
    if (flush && m_valid && m_rd != 0) remove(m_rd);
    if (acc && d.rd != 0) outstanding.push_back(d.rd);
    if (m_valid && out_ready && !flush && m_rd != 0)
      ex_q.push_back(m_rd);
    if (flush) m_valid = 1'b0;
    else if (acc) begin
      m_valid = 1'b1;
      m_pc = in_pc; m_imm = d.imm; m_rd = d.rd;
      m_rs1 = v1; m_rs2 = v2; m_oc = d.oc;
      m_f3 = in_instr[14:12]; m_f7 = in_instr[30];
      m_ill = d.ill;
    end else if (m_valid && out_ready) m_valid = 1'b0;
    @(negedge clk);
    chk("out_valid", out_valid, m_valid);
    if (m_valid) begin
      chk("out_pc", o_pc, m_pc);
      chk("out_imm", o_imm, m_imm);
      chk("out_rd", o_rd, m_rd);
      chk("out_rs1", o_rs1, m_rs1);
      chk("out_rs2", o_rs2, m_rs2);
      chk("out_f3", o_f3, m_f3);
      chk("out_f7b5", o_f7, m_f7);
      chk("out_ill", o_ill, m_ill);
      if (!m_ill) chk("out_opclass", o_oc, m_oc);
    end
  endtask

  // Idle input and retire everything in flight
  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    flush     = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (outstanding.size() == 0 && !m_valid) break;
      wb_valid = 1'b0;
      wb_wen   = 1'b0;
      if (ex_q.size() > 0) begin
        wb_valid = 1'b1;
        wb_wen   = 1'b1;
        wb_rd    = 5'(ex_q.pop_front());
        wb_data  = $urandom;
      end
      cycle();
    end
    wb_valid = 1'b0;
    wb_wen   = 1'b0;
    chk("drain_left", outstanding.size(), 0);
  endtask

  task automatic offer(logic [31:0] w);
    in_valid = 1'b1;
    in_instr = w;
    in_pc    = $urandom & 32'hFFFF_FFFC;
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  oc;
    logic        ill;
  } vec_t;

  vec_t        vt[12];
  logic [6:0]  ops[12];

  initial begin
    vt[0]  = '{32'h00500093, 32'h00000005, 5'd1,  OC_OPIMM,  1'b0};
    vt[1]  = '{32'hFE000EE3, 32'hFFFFFFFC, 5'd0,  OC_BRANCH, 1'b0};
    vt[2]  = '{32'h123451B7, 32'h12345000, 5'd3,  OC_LUI,    1'b0};
    vt[3]  = '{32'hFFFFFFFF, 32'h00000000, 5'd0,  OC_LUI,    1'b1};
    vt[4]  = '{32'hFE20AC23, 32'hFFFFFFF8, 5'd0,  OC_STORE,  1'b0};
    vt[5]  = '{32'h008000EF, 32'h00000008, 5'd1,  OC_JAL,    1'b0};
    vt[6]  = '{32'hFFFFF517, 32'hFFFFF000, 5'd10, OC_AUIPC,  1'b0};
    vt[7]  = '{32'hFFF3A303, 32'hFFFFFFFF, 5'd6,  OC_LOAD,   1'b0};
    vt[8]  = '{32'h40108133, 32'h00000000, 5'd2,  OC_OP,     1'b0};
    vt[9]  = '{32'h0FF0000F, 32'h00000000, 5'd0,  OC_FENCE,  1'b0};
    vt[10] = '{32'h00000073, 32'h00000000, 5'd0,  OC_SYSTEM, 1'b0};
    vt[11] = '{32'h00008067, 32'h00000000, 5'd0,  OC_JALR,   1'b0};
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
            7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h7F};

    foreach (rf[i]) rf[i] = $urandom;
    rf[0]     = 32'd0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 32'd0;
    in_pc     = 32'd0;
    wb_valid  = 1'b0;
    wb_wen    = 1'b0;
    wb_rd     = 5'd0;
    wb_data   = 32'd0;
    flush     = 1'b0;
    out_ready = 1'b1;
    auto_wb   = 1'b0;
    m_valid   = 1'b0;
    {m_pc, m_imm, m_rs1, m_rs2} = '0;
    {m_rd, m_oc, m_f3, m_f7, m_ill} = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_pc", o_pc, 0);
    chk("rst_imm", o_imm, 0);
    chk("rst_rs1", o_rs1, 0);
    chk("rst_rd", o_rd, 0);
    chk("rst_ready", in_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Decode table
    for (int i = 0; i < 12; i++) begin
      offer(vt[i].instr);
      out_ready = 1'b1;
      cycle();
      in_valid = 1'b0;
      chk("tbl_valid", out_valid, 1);
      chk("tbl_imm", o_imm, vt[i].imm);
      chk("tbl_rd", o_rd, vt[i].rd);
      chk("tbl_ill", o_ill, vt[i].ill);
      if (!vt[i].ill) chk("tbl_oc", o_oc, vt[i].oc);
      drain();
    end

    // RAW stall then accept with bypass
    offer(32'h00500093);
    cycle();
    offer(32'h00108133);
    cycle();
    chk("raw_stall0", last_rdy, 0);
    cycle();
    chk("raw_stall1", last_rdy, 0);
    wb_valid = 1'b1;
    wb_wen   = 1'b1;
    wb_rd    = 5'd1;
    wb_data  = 32'h5;
    if (ex_q.size() > 0) void'(ex_q.pop_front());
    cycle();
    wb_valid = 1'b0;
    wb_wen   = 1'b0;
    in_valid = 1'b0;
    chk("raw_accept", last_rdy, 1);
    chk("raw_rs1", o_rs1, 32'h5);
    chk("raw_rs2", o_rs2, 32'h5);
    chk("raw_rd", o_rd, 5'd2);
    drain();

    // Flush a held LUI x3
    out_ready = 1'b0;
    offer(32'h123451B7);
    cycle();
    offer(32'h00100213);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("flush_noacc", last_rdy, 0);
    chk("flush_valid", out_valid, 0);
    out_ready = 1'b1;
    offer(32'h123451B7);
    cycle();
    chk("flush_clr3", last_rdy, 1);
    drain();

    // Illegal opcode then no stall
    offer(32'hFFFFFFFF);
    cycle();
    chk("ill_flag", o_ill, 1);
    chk("ill_rd", o_rd, 0);
    offer(32'h00500293);
    cycle();
    chk("ill_next", last_rdy, 1);
    drain();

    // Backpressure for three cycles
    out_ready = 1'b0;
    offer(32'h00700313);
    cycle();
    offer(32'h00800393);
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("bp_ready", last_rdy, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_imm", o_imm, 32'd7);
      chk("bp_rd", o_rd, 5'd6);
    end
    drain();

    // Random traffic
    auto_wb = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(3, 0) != 0);
      in_instr  = {$urandom} & 32'hFFFF_FF80;
      in_instr[6:0] = ops[$urandom_range(11, 0)];
      in_pc     = $urandom;
      out_ready = ($urandom_range(3, 0) != 0);
      flush     = ($urandom_range(19, 0) == 0);
      cycle();
    end
    auto_wb  = 1'b0;

    // Reset in the middle of traffic
    in_valid  = 1'b0;
    wb_valid  = 1'b0;
    wb_wen    = 1'b0;
    flush     = 1'b0;
    rst_n     = 1'b0;
    #2;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_rd", o_rd, 0);
    m_valid = 1'b0;
    outstanding.delete();
    ex_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    out_ready = 1'b1;
    offer(32'h00108133);
    cycle();
    chk("post_rst_rdy", last_rdy, 1);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
